// File: rtl/ifetch_pkg.sv
// ifetch_pkg -- shared definitions for the instruction fetch unit.
//   NOP      : canonical RISC-V NOP (addi x0, x0, 0) shown whenever no
//              valid instruction is presented or a fetch faulted.
//   state_t  : fetch FSM state encoding.
package ifetch_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        VALID,
        DRAIN
    } state_t;

endpackage

// File: rtl/ifetch_pf_buffer.sv
// ifetch_pf_buffer -- one-entry next-line prefetch buffer.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   clear         : drop the buffered entry (flush or buffer miss)
//   issue         : a prefetch of issue_addr is starting on the bus
//   fill          : prefetch response arrived (fill_data / fill_err)
//   consume       : the core took the buffered entry
//   lookup_addr   : address the core is requesting
//   hit           : buffer holds a valid entry for lookup_addr
//   data, err     : buffered word and its bus-error flag
module ifetch_pf_buffer
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        issue,
    input  logic [31:0] issue_addr,
    input  logic        fill,
    input  logic [31:0] fill_data,
    input  logic        fill_err,
    input  logic        consume,
    input  logic [31:0] lookup_addr,
    output logic        hit,
    output logic [31:0] data,
    output logic        err
);

    logic        pf_valid_reg;
    logic [31:0] pf_addr_reg;
    logic [31:0] pf_data_reg;
    logic        pf_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pf_valid_reg <= 1'b0;
            pf_addr_reg  <= 32'h0;
            pf_data_reg  <= NOP;
            pf_err_reg   <= 1'b0;
        end else begin
            // The address is latched when the prefetch starts so that a
            // later fill only needs to carry data.
            if (issue) begin
                pf_addr_reg <= issue_addr;
            end
            if (clear) begin
                pf_valid_reg <= 1'b0;
            end else if (fill) begin
                pf_valid_reg <= 1'b1;
                pf_data_reg  <= fill_data;
                pf_err_reg   <= fill_err;
            end else if (consume) begin
                pf_valid_reg <= 1'b0;
            end
        end
    end

    assign hit  = pf_valid_reg && (lookup_addr == pf_addr_reg);
    assign data = pf_data_reg;
    assign err  = pf_err_reg;

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit -- single-outstanding instruction fetch unit.
// Optional feature: define IFETCH_PREFETCH_EN to add a one-entry next-line
// prefetch buffer (ifetch_pf_buffer); the default build has none.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   core_req, core_pc        : core fetch request and address
//   flush                    : redirect, kills any in-flight fetch
//   instr_ready              : core accepts presented instruction
//   instr_valid, instruction,
//   fetch_err                : fetch result towards the core
//   imem_req, imem_addr,
//   imem_gnt                 : bus address phase
//   imem_rvalid, imem_rdata,
//   imem_err                 : bus response phase
module ifetch_unit
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic [31:0] core_pc,
    input  logic        flush,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic        fetch_err,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err
);

    state_t      state_reg;
    logic [29:0] fetch_pc_reg;   // word address; misaligned PCs never reach the bus
    logic        valid_reg;
    logic [31:0] instr_reg;
    logic        err_reg;
    logic        req_reg;
    logic        kill_reg;       // flush seen while waiting for gnt
    logic        pf_active_reg;  // current bus transaction is a prefetch

    logic        accept_req;
    logic [29:0] next_word;
    logic        pf_hit;
    logic [31:0] pf_data;
    logic        pf_err;

    assign accept_req = (state_reg == IDLE) && core_req && !flush;
    assign next_word  = fetch_pc_reg + 30'd1;

`ifdef IFETCH_PREFETCH_EN
    localparam bit PF_EN = 1'b1;

    logic pf_issue;
    logic pf_fill;
    logic pf_clear;
    logic pf_consume;

    assign pf_issue   = (state_reg == VALID) && instr_ready && !flush && !err_reg;
    assign pf_fill    = (state_reg == DATA) && pf_active_reg && imem_rvalid && !flush;
    assign pf_consume = accept_req && pf_hit;
    assign pf_clear   = flush || (accept_req && !pf_hit);

    ifetch_pf_buffer u_pf_buffer (
        .clk         (clk),
        .rst         (rst),
        .clear       (pf_clear),
        .issue       (pf_issue),
        .issue_addr  ({next_word, 2'b00}),
        .fill        (pf_fill),
        .fill_data   (imem_rdata),
        .fill_err    (imem_err),
        .consume     (pf_consume),
        .lookup_addr (core_pc),
        .hit         (pf_hit),
        .data        (pf_data),
        .err         (pf_err)
    );
`else
    localparam bit PF_EN = 1'b0;

    assign pf_hit  = 1'b0;
    assign pf_data = NOP;
    assign pf_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            fetch_pc_reg  <= 30'h0;
            valid_reg     <= 1'b0;
            instr_reg     <= NOP;
            err_reg       <= 1'b0;
            req_reg       <= 1'b0;
            kill_reg      <= 1'b0;
            pf_active_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept_req) begin
                        fetch_pc_reg <= core_pc[31:2];
                        if (pf_hit) begin
                            state_reg <= VALID;
                            valid_reg <= 1'b1;
                            instr_reg <= pf_err ? NOP : pf_data;
                            err_reg   <= pf_err;
                        end else if (core_pc[1:0] != 2'b00) begin
                            state_reg <= VALID;
                            valid_reg <= 1'b1;
                            instr_reg <= NOP;
                            err_reg   <= 1'b1;
                        end else begin
                            state_reg     <= ADDR;
                            req_reg       <= 1'b1;
                            kill_reg      <= 1'b0;
                            pf_active_reg <= 1'b0;
                        end
                    end
                end
                ADDR: begin
                    // The address phase cannot be withdrawn; a flush only
                    // marks the response for discarding.
                    if (flush) begin
                        kill_reg <= 1'b1;
                    end
                    if (imem_gnt) begin
                        req_reg   <= 1'b0;
                        state_reg <= (flush || kill_reg) ? DRAIN : DATA;
                    end
                end
                DATA: begin
                    if (flush) begin
                        state_reg <= imem_rvalid ? IDLE : DRAIN;
                    end else if (imem_rvalid) begin
                        if (pf_active_reg) begin
                            // Prefetch result goes to the buffer, not the core.
                            state_reg <= IDLE;
                        end else begin
                            state_reg <= VALID;
                            valid_reg <= 1'b1;
                            instr_reg <= imem_err ? NOP : imem_rdata;
                            err_reg   <= imem_err;
                        end
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        state_reg <= IDLE;
                    end
                end
                VALID: begin
                    // flush wins over instr_ready and suppresses the prefetch.
                    if (flush || instr_ready) begin
                        valid_reg <= 1'b0;
                        instr_reg <= NOP;
                        err_reg   <= 1'b0;
                        if (PF_EN && !flush && !err_reg) begin
                            state_reg     <= ADDR;
                            fetch_pc_reg  <= next_word;
                            req_reg       <= 1'b1;
                            kill_reg      <= 1'b0;
                            pf_active_reg <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign instr_valid = valid_reg;
    assign instruction = instr_reg;
    assign fetch_err   = err_reg;
    assign imem_req    = req_reg;
    assign imem_addr   = {fetch_pc_reg, 2'b00};

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit -- directed scenarios followed by a randomized run in which
// a bench-side memory responder answers bus requests with random gnt/rvalid
// delays, and each core request is checked against the value the address
// must produce (memory contents, bus error map, alignment rule).
// Build with +define+IFETCH_PREFETCH_EN to exercise the prefetch buffer.
module tb_ifetch_unit;
    import ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req;
    logic [31:0] core_pc;
    logic        flush;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        fetch_err;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;

    int checks = 0;
    int errors = 0;

    ifetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .core_req    (core_req),
        .core_pc     (core_pc),
        .flush       (flush),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .fetch_err   (fetch_err),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .imem_err    (imem_err)
    );

    always #5 clk = ~clk;

    // Memory image and bus-error map seen by the randomized run.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic errf(input logic [31:0] a);
        return a[4:2] == 3'b101;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; core_req = 1'b0; flush = 1'b0; instr_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_err = 1'b0;
        tick;
        rst = 1'b0;
    endtask

    // randomized-run state
    bit          pend, last_req, last_gnt, waiting, got, have_prev, abort;
    int          pend_cnt, wait_cnt, ready_delay, gap, n_txn, r;
    logic [31:0] pend_addr, last_addr, cur_pc, prev_pc, exp_instr;
    logic        exp_err;

    initial begin
        core_pc = 32'h0; imem_rdata = 32'h0;
        do_reset;
        tick;
        rst = 1'b1;
        tick;
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instruction", instruction, NOP);
        chk("rst_fetch_err", fetch_err, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        rst = 1'b0;

        // zero-wait fetch
        core_req = 1'b1; core_pc = 32'h100; imem_gnt = 1'b1;
        tick;
        chk("zw_c1_req", imem_req, 1);
        chk("zw_c1_addr", imem_addr, 32'h100);
        chk("zw_c1_valid", instr_valid, 0);
        core_req = 1'b0;
        tick;
        chk("zw_c2_req", imem_req, 0);
        chk("zw_c2_valid", instr_valid, 0);
        imem_rvalid = 1'b1; imem_rdata = 32'hABCD_0537; imem_err = 1'b0;
        tick;
        imem_rvalid = 1'b0;
        chk("zw_c3_valid", instr_valid, 1);
        chk("zw_c3_instr", instruction, 32'hABCD_0537);
        chk("zw_c3_err", fetch_err, 0);
        instr_ready = 1'b1;
        tick;
        instr_ready = 1'b0;
        chk("zw_c4_valid", instr_valid, 0);
        chk("zw_c4_instr", instruction, NOP);
        do_reset;

        // misaligned fetch
        core_req = 1'b1; core_pc = 32'h102; imem_gnt = 1'b1;
        tick;
        core_req = 1'b0;
        chk("mis_c1_valid", instr_valid, 1);
        chk("mis_c1_instr", instruction, NOP);
        chk("mis_c1_err", fetch_err, 1);
        chk("mis_c1_req", imem_req, 0);
        instr_ready = 1'b1;
        tick;
        instr_ready = 1'b0;
        chk("mis_c2_valid", instr_valid, 0);
        chk("mis_c2_req", imem_req, 0);
        tick;
        chk("mis_c3_req", imem_req, 0);
        do_reset;

        // flush in DATA, late response discarded
        core_req = 1'b1; core_pc = 32'h200; imem_gnt = 1'b1;
        tick;
        core_req = 1'b0;
        tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick;
        imem_rvalid = 1'b0;
        chk("fl_valid", instr_valid, 0);
        chk("fl_instr", instruction, NOP);
        core_req = 1'b1; core_pc = 32'h300;
        tick;
        core_req = 1'b0;
        chk("fl_idle_valid", instr_valid, 0);
        chk("fl_idle_req", imem_req, 1);
        chk("fl_idle_addr", imem_addr, 32'h300);
        do_reset;

        // flush together with instr_ready in VALID
        core_req = 1'b1; core_pc = 32'h600; imem_gnt = 1'b1;
        tick;
        core_req = 1'b0;
        tick;
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0537;
        tick;
        imem_rvalid = 1'b0;
        chk("flr_valid_before", instr_valid, 1);
        flush = 1'b1; instr_ready = 1'b1;
        tick;
        flush = 1'b0; instr_ready = 1'b0;
        chk("flr_valid_after", instr_valid, 0);
        chk("flr_no_prefetch", imem_req, 0);
        do_reset;

        // gnt withheld for 5 cycles
        core_req = 1'b1; core_pc = 32'h400; imem_gnt = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick;
            core_req = 1'b0;
            chk("stall_req", imem_req, 1);
            chk("stall_addr", imem_addr, 32'h400);
            chk("stall_valid", instr_valid, 0);
        end
        imem_gnt = 1'b1;
        tick;
        chk("stall_req_drop", imem_req, 0);
        chk("stall_valid_wait", instr_valid, 0);
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        tick;
        imem_rvalid = 1'b0;
        chk("stall_valid", instr_valid, 1);
        chk("stall_instr", instruction, 32'h1234_5678);
        do_reset;

        // reset in ADDR, then stray rvalid
        core_req = 1'b1; core_pc = 32'h500; imem_gnt = 1'b0;
        tick;
        core_req = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rstaddr_valid", instr_valid, 0);
        chk("rstaddr_instr", instruction, NOP);
        chk("rstaddr_err", fetch_err, 0);
        chk("rstaddr_req", imem_req, 0);
        chk("rstaddr_addr", imem_addr, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0000;
        tick;
        imem_rvalid = 1'b0;
        chk("stray_valid", instr_valid, 0);
        chk("stray_req", imem_req, 0);
        chk("stray_instr", instruction, NOP);
        tick;
        chk("stray_valid2", instr_valid, 0);

`ifdef IFETCH_PREFETCH_EN
        // prefetch wrap from 0xFFFFFFFC to 0x0, then a buffer hit
        do_reset;
        core_req = 1'b1; core_pc = 32'hFFFF_FFFC; imem_gnt = 1'b1;
        tick;
        core_req = 1'b0;
        tick;
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_0013;
        tick;
        imem_rvalid = 1'b0;
        chk("pf_first_valid", instr_valid, 1);
        instr_ready = 1'b1;
        tick;
        instr_ready = 1'b0;
        chk("pf_req", imem_req, 1);
        chk("pf_addr", imem_addr, 32'h0);
        chk("pf_no_valid", instr_valid, 0);
        tick;
        imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0093;
        tick;
        imem_rvalid = 1'b0;
        core_req = 1'b1; core_pc = 32'h0;
        tick;
        core_req = 1'b0;
        chk("pf_hit_valid", instr_valid, 1);
        chk("pf_hit_instr", instruction, 32'h00A0_0093);
        chk("pf_hit_err", fetch_err, 0);
        chk("pf_hit_no_bus", imem_req, 0);
`endif

        // randomized run
        do_reset;
        pend = 0; last_req = 0; last_gnt = 0; waiting = 0; got = 0;
        have_prev = 0; abort = 0; gap = 0; n_txn = 0; prev_pc = 0;
        for (int cyc = 0; cyc < 20000 && n_txn < 150 && !abort; cyc++) begin
            tick;
            // bus side
            if (last_req && !last_gnt) begin
                chk("bus_req_hold", imem_req, 1);
                chk("bus_addr_hold", imem_addr, last_addr);
            end
            if (last_req && last_gnt) begin
                chk("bus_one_outstanding", pend, 0);
                pend = 1; pend_addr = last_addr; pend_cnt = $urandom_range(0, 2);
            end
            imem_rvalid = 1'b0; imem_rdata = $urandom; imem_err = 1'($urandom);
            if (pend) begin
                if (pend_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = memf(pend_addr);
                    imem_err    = errf(pend_addr);
                    pend = 0;
                end else begin
                    pend_cnt--;
                end
            end
            imem_gnt  = ($urandom_range(0, 2) != 0);
            last_req  = imem_req;
            last_gnt  = imem_gnt;
            last_addr = imem_addr;

            // core side
            if (!instr_valid) chk("nop_when_invalid", instruction, NOP);
            instr_ready = 1'b0;
            if (waiting) begin
                if (instr_valid) begin
                    if (!got) begin
                        exp_err   = (cur_pc[1:0] != 2'b00) || errf(cur_pc);
                        exp_instr = exp_err ? NOP : memf(cur_pc);
                        chk("rnd_instr", instruction, exp_instr);
                        chk("rnd_err", fetch_err, exp_err);
                        $display("txn %0d pc=%h instr=%h err=%b exp=%h/%b",
                                 n_txn, cur_pc, instruction, fetch_err, exp_instr, exp_err);
                        got = 1; core_req = 1'b0; ready_delay = $urandom_range(0, 2);
                    end
                    if (ready_delay == 0) begin
                        instr_ready = 1'b1; waiting = 0; n_txn++;
                        gap = $urandom_range(0, 3);
                    end else begin
                        ready_delay--;
                    end
                end else begin
                    wait_cnt++;
                    checks++;
                    assert (wait_cnt <= 60 && !got) else begin
                        errors++;
                        $error("FAIL rnd_wait pc=%h waited=%0d got=%0d required=response within 60", cur_pc, wait_cnt, got);
                        abort = 1;
                    end
                end
            end else begin
                chk("rnd_spurious_valid", instr_valid, 0);
                if (gap > 0) begin
                    gap--;
                end else begin
                    r = $urandom_range(0, 9);
                    if (r < 3 && have_prev)  cur_pc = prev_pc + 32'd4;
                    else if (r == 3)         cur_pc = {$urandom_range(0, 255), 2'(1 + $urandom_range(0, 2))};
                    else if (r == 4)         cur_pc = 32'hFFFF_FFFC;
                    else                     cur_pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                    prev_pc = cur_pc; have_prev = 1;
                    core_req = 1'b1; core_pc = cur_pc;
                    waiting = 1; got = 0; wait_cnt = 0;
                end
            end
        end
        chk("rnd_txn_count", n_txn, 150);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
